ex_iter_alu: RTL
================

EX_ITER_ALU -- requirements
Module: ex_iter_alu

Interface
REQ-001 SHALL have clk  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have rdy  input  1  global run enable; low = pause, all state frozen.
REQ-004 SHALL have in_valid  input  1  an instruction is present from the ID/EX pipeline register.
REQ-005 SHALL have opcode  input  7  RV32I opcode.
REQ-006 SHALL have funct3  input  3  RV32I funct3.
REQ-007 SHALL have funct7  input  7  RV32I funct7 (imm[11:5] for OP-IMM).
REQ-008 SHALL have reg1  input  32  operand 1 (rs1 value).
REQ-009 SHALL have reg2  input  32  operand 2 (rs2 value, or sign-extended immediate for OP-IMM).
REQ-010 SHALL have wd  input  5  destination register address.
REQ-011 SHALL have wreg  input  1  destination write enable.
REQ-012 SHALL have stall_req  output  1  back-pressure to the ID/EX stage; upstream holds its outputs while high.
REQ-013 SHALL have out_valid  output  1  result present for the EX/MEM stage, one cycle per instruction.
REQ-014 SHALL have out_wd  output  5  destination address of the result.
REQ-015 SHALL have out_wreg  output  1  write enable of the result.
REQ-016 SHALL have out_wdata  output  32  result value.

Function
REQ-017 SHALL accept an instruction on a rising edge where rdy=1, in_valid=1 and the state is IDLE.
REQ-018 SHALL implement states IDLE and SHIFT only; the reset state is IDLE.
REQ-019 SHALL execute OP (0110011) and OP-IMM (0010011): ADD/ADDI, SUB (OP only, funct7[5]=1), AND, OR, XOR, SLT (signed), SLTU (unsigned), SLL, SRL, SRA.
REQ-020 SHALL select SRA/SRAI when funct7[5]=1 and funct3=101; otherwise SRL/SRLI.
REQ-021 SHALL use 32-bit wrap-around add/sub with no overflow flag; SLT/SLTU result = 32'd0 or 32'd1.
REQ-022 SHALL, for any other opcode, produce out_valid=1 with out_wreg=0 and out_wdata=0, with 1-edge latency.
REQ-023 SHALL register non-shift results on the accept edge: out_valid=1, out_wd=wd, out_wreg=wreg, out_wdata=result, visible the cycle after that edge.
REQ-024 SHALL take the shift amount as s=reg2[4:0]; if s=0, the result = reg1 with the same 1-edge latency as non-shift ops.
REQ-025 SHALL, for a shift with s>0, load reg1 into a work register, load a 5-bit counter with s, latch wd/wreg/type, and go to SHIFT on the accept edge.
REQ-026 SHALL, on each SHIFT edge with rdy=1, shift the work register 1 bit (SLL zero fill; SRL zero fill; SRA sign fill) and decrement the counter.
REQ-027 SHALL, on the SHIFT edge where the counter goes 1 -> 0, return to IDLE and present the result with out_valid=1; total latency is s+1 edges from acceptance.
REQ-028 SHALL drive stall_req=1 combinationally whenever the state is SHIFT, and 0 in IDLE.
REQ-029 SHALL ignore in_valid and the instruction inputs while in SHIFT.
REQ-030 SHALL hold out_valid high for exactly one cycle per instruction; on any edge with rdy=1 and no result, drive out_valid=0, out_wreg=0, out_wd=0, out_wdata=0.
REQ-031 SHALL, while rdy=0, hold state, counter, work register and all outputs unchanged, including out_valid.
REQ-032 SHALL drive out_wreg=0 whenever wd=0, regardless of wreg.

Reset
REQ-033 SHALL, on a rising edge with rst=1, force IDLE, counter=0, work register=0, out_valid=0, out_wd=0, out_wreg=0, out_wdata=0.
REQ-034 SHALL abort any shift in progress on reset with no result emitted; stall_req=0 the following cycle.
REQ-035 SHALL give rst priority over rdy; the block resets even when rdy=0.

Verification
REQ-036 SHALL verify ADD reg1=32'h7FFFFFFF, reg2=1, wd=5 -> next cycle out_valid=1, out_wd=5, out_wdata=32'h80000000, stall_req=0 throughout.
REQ-037 SHALL verify SLT reg1=32'hFFFFFFFF, reg2=1 -> out_wdata=1; SLTU with the same operands -> out_wdata=0.
REQ-038 SHALL verify SRA reg1=32'h80000000, reg2=31 -> stall_req high for 31 cycles, then out_valid=1 for one cycle with out_wdata=32'hFFFFFFFF, 32 edges after acceptance.
REQ-039 SHALL verify SLL reg1=1, reg2=4, with rdy dropped for 3 cycles mid-shift -> result 32'h10 delayed by exactly 3 cycles, all outputs frozen while rdy=0.
REQ-040 SHALL verify rst asserted during an SRL with s=20 -> IDLE, all outputs 0, no out_valid pulse, next ADD accepted normally.
REQ-041 SHALL verify back-to-back ADD then SLL s=0 then XOR -> three consecutive out_valid cycles with stall_req never asserted.

Source files
------------

// File: rtl/ex_iter_alu.sv
// Execute-stage ALU for RV32I OP/OP-IMM. Shifts run one bit per cycle in an
// iterative unit and back-pressure the ID/EX stage while they are in flight.
module ex_iter_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  input  logic [4:0]  wd,
  input  logic        wreg,
  output logic        stall_req,
  output logic        out_valid,
  output logic [4:0]  out_wd,
  output logic        out_wreg,
  output logic [31:0] out_wdata
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

  logic [0:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  wd_q, wd_d;
  logic        wreg_q, wreg_d;
  logic [1:0]  sh_q, sh_d;
  logic        out_valid_q, out_valid_d;
  logic [4:0]  out_wd_q, out_wd_d;
  logic        out_wreg_q, out_wreg_d;
  logic [31:0] out_wdata_q, out_wdata_d;

  logic        is_alu;
  logic        is_shift;
  logic [4:0]  shamt;
  logic [1:0]  sh_type;
  logic [31:0] alu_res;
  logic [31:0] work_shift;
  logic        unused_funct7;

  // Only funct7[5] distinguishes SUB/SRA; the other bits carry no meaning here.
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  assign is_alu   = (opcode == OPC_OP) || (opcode == OPC_OPIMM);
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign shamt    = reg2[4:0];
  assign sh_type  = (funct3 == 3'b001) ? SH_SLL : (funct7[5] ? SH_SRA : SH_SRL);

  always_comb begin
    alu_res = 32'd0;
    case (funct3)
      3'b000:  alu_res = (opcode == OPC_OP && funct7[5]) ? (reg1 - reg2) : (reg1 + reg2);
      3'b010:  alu_res = {31'd0, $signed(reg1) < $signed(reg2)};
      3'b011:  alu_res = {31'd0, reg1 < reg2};
      3'b100:  alu_res = reg1 ^ reg2;
      3'b110:  alu_res = reg1 | reg2;
      3'b111:  alu_res = reg1 & reg2;
      default: alu_res = reg1;  // zero-amount shift passes rs1 through
    endcase
  end

  always_comb begin
    case (sh_q)
      SH_SLL:  work_shift = {work_q[30:0], 1'b0};
      SH_SRL:  work_shift = {1'b0, work_q[31:1]};
      default: work_shift = {work_q[31], work_q[31:1]};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    sh_d        = sh_q;
    out_valid_d = out_valid_q;
    out_wd_d    = out_wd_q;
    out_wreg_d  = out_wreg_q;
    out_wdata_d = out_wdata_q;
    if (rdy) begin
      out_valid_d = 1'b0;
      out_wd_d    = 5'd0;
      out_wreg_d  = 1'b0;
      out_wdata_d = 32'd0;
      if (state_q == S_IDLE) begin
        if (in_valid) begin
          if (is_alu && is_shift && shamt != 5'd0) begin
            state_d = S_SHIFT;
            cnt_d   = shamt;
            work_d  = reg1;
            wd_d    = wd;
            wreg_d  = wreg;
            sh_d    = sh_type;
          end else begin
            out_valid_d = 1'b1;
            out_wd_d    = wd;
            out_wreg_d  = is_alu && wreg && (wd != 5'd0);
            out_wdata_d = is_alu ? alu_res : 32'd0;
          end
        end
      end else begin
        work_d = work_shift;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          out_wd_d    = wd_q;
          out_wreg_d  = wreg_q && (wd_q != 5'd0);
          out_wdata_d = work_shift;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      work_q      <= 32'd0;
      wd_q        <= 5'd0;
      wreg_q      <= 1'b0;
      sh_q        <= SH_SLL;
      out_valid_q <= 1'b0;
      out_wd_q    <= 5'd0;
      out_wreg_q  <= 1'b0;
      out_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      sh_q        <= sh_d;
      out_valid_q <= out_valid_d;
      out_wd_q    <= out_wd_d;
      out_wreg_q  <= out_wreg_d;
      out_wdata_q <= out_wdata_d;
    end
  end

  assign stall_req = (state_q == S_SHIFT);
  assign out_valid = out_valid_q;
  assign out_wd    = out_wd_q;
  assign out_wreg  = out_wreg_q;
  assign out_wdata = out_wdata_q;

endmodule
